// File: rtl/axi_sram_responder_pkg.sv
// Shared AXI definitions: bus widths and burst encodings used by the AXI interface
// and by every AXI slave in the design.
package axi_sram_responder_pkg;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

endpackage

// File: rtl/axi4_interface.sv
// AXI4 bundle carrying the address, data and response fields used by the
// single-outstanding SRAM responder.
interface axi4_interface
  import axi_sram_responder_pkg::*;
();

  logic                      m_awvalid;
  logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
  logic [AXI_LEN_WIDTH-1:0]  m_awlen;
  logic                      s_awready;

  logic                      m_wvalid;
  logic [AXI_DATA_WIDTH-1:0] m_wdata;
  logic                      m_wlast;
  logic                      s_wready;

  logic                      s_bvalid;
  logic                      m_bready;

  logic                      m_arvalid;
  logic [AXI_ADDR_WIDTH-1:0] m_araddr;
  logic [AXI_LEN_WIDTH-1:0]  m_arlen;
  logic                      s_arready;

  logic                      s_rvalid;
  logic [AXI_DATA_WIDTH-1:0] s_rdata;
  logic                      m_rready;

  modport slave (
    input  m_awvalid, m_awaddr, m_awlen,
    output s_awready,
    input  m_wvalid, m_wdata, m_wlast,
    output s_wready,
    output s_bvalid,
    input  m_bready,
    input  m_arvalid, m_araddr, m_arlen,
    output s_arready,
    output s_rvalid, s_rdata,
    input  m_rready
  );

endinterface

// File: rtl/axi_sram_responder_sram.sv
// Simple dual-port synchronous SRAM: one write port, one read port with a
// single registered cycle of read latency. Contents are never reset.
module sram_1r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 1024
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [$clog2(SIZE)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [$clog2(SIZE)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [SIZE];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave serving one INCR burst at a time from on-chip SRAM, with
// round-robin arbitration between the write and read address channels.
module axi_sram_responder
  import axi_sram_responder_pkg::*;
#(
  parameter int MEM_SIZE = 65536
) (
  input logic          clk,
  input logic          reset,
  axi4_interface.slave axi_bus
);

  localparam int BYTE_BITS = $clog2(AXI_DATA_WIDTH / 8);
  localparam int WORD_BITS = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BURST,
    WRITE_RESP,
    READ_BURST
  } state_t;

  state_t                    r_state;
  logic [WORD_BITS-1:0]      r_addr;
  logic [7:0]                r_len;
  logic [7:0]                r_count;
  logic                      r_lastWasWrite;
  logic                      r_wready;
  logic                      r_bvalid;
  logic                      r_rvalid;

  logic                      w_idle;
  logic                      w_grantWrite;
  logic                      w_grantRead;
  logic                      w_wBeat;
  logic                      w_rBeat;
  logic [WORD_BITS-1:0]      w_awWord;
  logic [WORD_BITS-1:0]      w_arWord;
  logic [WORD_BITS-1:0]      w_rdAddr;
  logic [AXI_DATA_WIDTH-1:0] w_rdata;
  logic                      w_unused;

  // Upper address bits are dropped on purpose so addresses alias modulo MEM_SIZE.
  assign w_awWord = axi_bus.m_awaddr[WORD_BITS+BYTE_BITS-1:BYTE_BITS];
  assign w_arWord = axi_bus.m_araddr[WORD_BITS+BYTE_BITS-1:BYTE_BITS];
  assign w_unused = ^{axi_bus.m_wlast,
                      axi_bus.m_awaddr[AXI_ADDR_WIDTH-1:WORD_BITS+BYTE_BITS],
                      axi_bus.m_awaddr[BYTE_BITS-1:0],
                      axi_bus.m_araddr[AXI_ADDR_WIDTH-1:WORD_BITS+BYTE_BITS],
                      axi_bus.m_araddr[BYTE_BITS-1:0]};

  // On a tie the channel that lost last time wins.
  assign w_idle       = (r_state == IDLE);
  assign w_grantWrite = w_idle && axi_bus.m_awvalid && (!axi_bus.m_arvalid || !r_lastWasWrite);
  assign w_grantRead  = w_idle && axi_bus.m_arvalid && (!axi_bus.m_awvalid || r_lastWasWrite);
  assign w_wBeat      = r_wready && axi_bus.m_wvalid;
  assign w_rBeat      = r_rvalid && axi_bus.m_rready;

  assign axi_bus.s_awready = w_grantWrite;
  assign axi_bus.s_arready = w_grantRead;
  assign axi_bus.s_wready  = r_wready;
  assign axi_bus.s_bvalid  = r_bvalid;
  assign axi_bus.s_rvalid  = r_rvalid;
  assign axi_bus.s_rdata   = w_rdata;

  // Re-reading the current word under back-pressure keeps s_rdata stable.
  always_comb begin
    w_rdAddr = r_addr;
    if (w_grantRead) begin
      w_rdAddr = w_arWord;
    end else if (w_rBeat) begin
      w_rdAddr = r_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_len          <= '0;
      r_count        <= '0;
      r_lastWasWrite <= 1'b0;
      r_wready       <= 1'b0;
      r_bvalid       <= 1'b0;
      r_rvalid       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantWrite) begin
            r_addr         <= w_awWord;
            r_len          <= axi_bus.m_awlen;
            r_count        <= '0;
            r_lastWasWrite <= 1'b1;
            r_wready       <= 1'b1;
            r_state        <= WRITE_BURST;
          end else if (w_grantRead) begin
            r_addr         <= w_arWord;
            r_len          <= axi_bus.m_arlen;
            r_count        <= '0;
            r_lastWasWrite <= 1'b0;
            r_rvalid       <= 1'b1;
            r_state        <= READ_BURST;
          end
        end
        WRITE_BURST: begin
          if (w_wBeat) begin
            r_addr <= r_addr + 1'b1;
            if (r_count == r_len) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_state  <= WRITE_RESP;
            end else begin
              r_count <= r_count + 8'd1;
            end
          end
        end
        WRITE_RESP: begin
          if (axi_bus.m_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        READ_BURST: begin
          if (w_rBeat) begin
            r_addr <= r_addr + 1'b1;
            if (r_count == r_len) begin
              r_rvalid <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_count <= r_count + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sram_1r1w #(
    .DATA_WIDTH(AXI_DATA_WIDTH),
    .SIZE      (MEM_SIZE)
  ) u_sram (
    .clk    (clk),
    .i_we   (w_wBeat),
    .i_waddr(r_addr),
    .i_wdata(axi_bus.m_wdata),
    .i_raddr(w_rdAddr),
    .o_rdata(w_rdata)
  );

endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder on a 16-word memory: directed scenarios plus random
// bursts, with read data checked by a queue-based scoreboard against a memory model.
module tb_axi_sram_responder;
  import axi_sram_responder_pkg::*;

  localparam int MEM_WORDS = 16;

  logic clk = 1'b0;
  logic reset;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] refMem [MEM_WORDS];
  logic [31:0] expQ [$];
  int   rxCount = 0;
  int   awCycle = 0;
  int   arCycle = 0;
  int   bHsCycle = 0;
  int   bRiseCount = 0;
  logic prevRvalid = 1'b0;
  logic prevBvalid = 1'b0;
  logic prevStall = 1'b0;
  logic [31:0] prevData = '0;

  axi4_interface axi_bus ();

  axi_sram_responder #(.MEM_SIZE(MEM_WORDS)) dut (
    .clk    (clk),
    .reset  (reset),
    .axi_bus(axi_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=handshake (cycle %0d)", name, cycle);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wordOf(input logic [31:0] addr);
    return int'((addr >> 2) % MEM_WORDS);
  endfunction

  // Monitor: pops the scoreboard on every R handshake and watches protocol rules.
  always @(negedge clk) begin
    if (reset) begin
      prevRvalid = 1'b0;
      prevBvalid = 1'b0;
      prevStall  = 1'b0;
    end else begin
      if (axi_bus.m_awvalid && axi_bus.s_awready) awCycle = cycle;
      if (axi_bus.m_arvalid && axi_bus.s_arready) arCycle = cycle;
      if (axi_bus.s_bvalid && axi_bus.m_bready) bHsCycle = cycle;
      if (axi_bus.s_bvalid && !prevBvalid) bRiseCount++;
      if (axi_bus.s_rvalid && !prevRvalid)
        checkOutput("r_first_beat_latency", 32'(cycle - arCycle), 32'd1);
      if ((axi_bus.s_wready || axi_bus.s_bvalid || axi_bus.s_rvalid) &&
          (axi_bus.m_awvalid || axi_bus.m_arvalid))
        checkOutput("addr_ready_outside_idle", {30'd0, axi_bus.s_awready, axi_bus.s_arready}, 32'd0);
      if (prevStall)
        checkOutput("r_hold_under_stall", axi_bus.s_rdata, prevData);
      if (axi_bus.s_rvalid && axi_bus.m_rready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL r_unexpected_beat actual=%0h expected=none", axi_bus.s_rdata);
        end else begin
          checkOutput("r_data", axi_bus.s_rdata, expQ.pop_front());
        end
        rxCount++;
      end
      prevStall  = axi_bus.s_rvalid && !axi_bus.m_rready;
      prevData   = axi_bus.s_rdata;
      prevRvalid = axi_bus.s_rvalid;
      prevBvalid = axi_bus.s_bvalid;
    end
  end

  // Write burst; abortAfter >= 0 stops after that many beats and skips the response.
  task automatic writeBurst(input logic [31:0] addr, input int len, input logic [31:0] base,
                            input bit randomData, input int stallPct, input int bDelay,
                            input int abortAfter);
    logic [31:0] dat [256];
    int word, k, n, riseBefore;
    word = wordOf(addr);
    riseBefore = bRiseCount;
    for (int i = 0; i <= len; i++) dat[i] = randomData ? $urandom : base + 32'(i);
    tick();
    axi_bus.m_awvalid = 1'b1;
    axi_bus.m_awaddr  = addr;
    axi_bus.m_awlen   = 8'(len);
    n = 0;
    @(negedge clk);
    while (!axi_bus.s_awready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!axi_bus.s_awready) begin
      failTimeout("aw_handshake");
      axi_bus.m_awvalid = 1'b0;
      return;
    end
    tick();
    axi_bus.m_awvalid = 1'b0;
    k = 0;
    n = 0;
    while (k <= len && (abortAfter < 0 || k < abortAfter) && n < 2000) begin
      if (stallPct > 0 && $urandom_range(0, 99) < stallPct) begin
        axi_bus.m_wvalid = 1'b0;
      end else begin
        axi_bus.m_wvalid = 1'b1;
        axi_bus.m_wdata  = dat[k];
        axi_bus.m_wlast  = (k == len);
      end
      @(negedge clk);
      if (axi_bus.m_wvalid && axi_bus.s_wready) begin
        refMem[(word + k) % MEM_WORDS] = dat[k];
        k++;
      end
      tick();
      n++;
    end
    axi_bus.m_wvalid = 1'b0;
    axi_bus.m_wlast  = 1'b0;
    if (abortAfter >= 0) return;
    if (k <= len) begin
      failTimeout("w_beats");
      return;
    end
    n = 0;
    @(negedge clk);
    while (!axi_bus.s_bvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!axi_bus.s_bvalid) begin
      failTimeout("b_valid_wait");
      return;
    end
    if (stallPct == 0) checkOutput("b_latency", 32'(cycle - awCycle), 32'(len + 2));
    for (int i = 0; i < bDelay; i++) begin
      tick();
      @(negedge clk);
      checkOutput("b_held", {31'd0, axi_bus.s_bvalid}, 32'd1);
    end
    tick();
    axi_bus.m_bready = 1'b1;
    @(negedge clk);
    checkOutput("b_valid_at_hs", {31'd0, axi_bus.s_bvalid}, 32'd1);
    tick();
    axi_bus.m_bready = 1'b0;
    checkOutput("b_rise_once", 32'(bRiseCount - riseBefore), 32'd1);
  endtask

  // Read burst; rmode 0 = always ready, 1 = ready pattern 1,0,0, 2 = random ready.
  task automatic readBurst(input logic [31:0] addr, input int len, input int rmode,
                           input bit checkArAfterB);
    int word, n, target;
    word = wordOf(addr);
    tick();
    axi_bus.m_arvalid = 1'b1;
    axi_bus.m_araddr  = addr;
    axi_bus.m_arlen   = 8'(len);
    n = 0;
    @(negedge clk);
    while (!axi_bus.s_arready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!axi_bus.s_arready) begin
      failTimeout("ar_handshake");
      axi_bus.m_arvalid = 1'b0;
      return;
    end
    if (checkArAfterB) checkOutput("ar_after_b", 32'(cycle - bHsCycle), 32'd1);
    for (int k = 0; k <= len; k++) expQ.push_back(refMem[(word + k) % MEM_WORDS]);
    target = rxCount + len + 1;
    tick();
    axi_bus.m_arvalid = 1'b0;
    n = 0;
    while (rxCount < target && n < 3000) begin
      case (rmode)
        0:       axi_bus.m_rready = 1'b1;
        1:       axi_bus.m_rready = (n % 3 == 0);
        default: axi_bus.m_rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      tick();
      n++;
    end
    axi_bus.m_rready = 1'b0;
    if (rxCount < target) begin
      failTimeout("r_beats");
      expQ.delete();
    end
  endtask

  task automatic checkAllLow(input string prefix);
    checkOutput({prefix, "_awready"}, {31'd0, axi_bus.s_awready}, 32'd0);
    checkOutput({prefix, "_arready"}, {31'd0, axi_bus.s_arready}, 32'd0);
    checkOutput({prefix, "_wready"},  {31'd0, axi_bus.s_wready},  32'd0);
    checkOutput({prefix, "_bvalid"},  {31'd0, axi_bus.s_bvalid},  32'd0);
    checkOutput({prefix, "_rvalid"},  {31'd0, axi_bus.s_rvalid},  32'd0);
  endtask

  task automatic simultaneous(input logic [31:0] addr, input bit expWriteFirst);
    fork
      writeBurst(addr, 0, 0, 1'b1, 0, 0, -1);
      readBurst(addr, 0, 0, 1'b0);
      begin
        tick();
        @(negedge clk);
        checkOutput("grant_aw", {31'd0, axi_bus.s_awready}, {31'd0, expWriteFirst});
        checkOutput("grant_ar", {31'd0, axi_bus.s_arready}, {31'd0, !expWriteFirst});
      end
    join
  endtask

  task automatic applyStimulus();
    // Fill the whole memory, then read it back at the same aliased address.
    writeBurst(32'h0000_1000, 15, 32'hA000_0000, 1'b0, 0, 0, -1);
    readBurst(32'h0000_1000, 15, 0, 1'b0);

    for (int i = 0; i < 8; i++) refMem[i] = refMem[i];
    writeBurst(32'h0000_0000, 7, 32'h0, 1'b0, 0, 1, -1);
    readBurst(32'h0000_0000, 7, 1, 1'b0);

    simultaneous(32'h0000_0014, 1'b1);
    writeBurst(32'h0000_0020, 0, 32'h5555_0000, 1'b0, 0, 0, -1);
    simultaneous(32'h0000_0014, 1'b0);

    writeBurst(32'h0000_0038, 3, 32'd1, 1'b0, 0, 0, -1);
    readBurst(32'h0000_0038, 3, 0, 1'b0);
    readBurst(32'h0000_0000, 1, 2, 1'b0);

    writeBurst(32'h0000_0000, 7, 32'h0, 1'b1, 0, 0, 3);
    reset = 1'b1;
    @(negedge clk);
    checkAllLow("in_reset");
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkAllLow("post_reset");
    readBurst(32'h0000_0000, 0, 0, 1'b0);

    fork
      writeBurst(32'h0000_0010, 3, 32'h0, 1'b1, 0, 5, -1);
      begin
        repeat (3) tick();
        readBurst(32'h0000_0010, 2, 0, 1'b1);
      end
    join

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1)
        writeBurst($urandom, $urandom_range(0, 20), 32'h0, 1'b1, $urandom_range(0, 40),
                   $urandom_range(0, 3), -1);
      else
        readBurst($urandom, $urandom_range(0, 20), 2, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    axi_bus.m_awvalid = 1'b0;
    axi_bus.m_awaddr  = '0;
    axi_bus.m_awlen   = '0;
    axi_bus.m_wvalid  = 1'b0;
    axi_bus.m_wdata   = '0;
    axi_bus.m_wlast   = 1'b0;
    axi_bus.m_bready  = 1'b0;
    axi_bus.m_arvalid = 1'b0;
    axi_bus.m_araddr  = '0;
    axi_bus.m_arlen   = '0;
    axi_bus.m_rready  = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) refMem[i] = '0;
    repeat (2) @(negedge clk);
    checkAllLow("reset");
    tick();
    reset = 1'b0;
    applyStimulus();
    repeat (3) tick();
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
